i2s_adc_rx: RTL and testbench



---
 rtl/i2s_adc_rx.sv | 156 +++++++++++++++
 tb/tb_i2s_adc_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// I2S ADC receive path: oversamples BCLK/LRCK/DATA in the clk domain and
// assembles left/right sample pairs, MSB first, one-bit I2S delay.
// Optional feature macro: I2S_RX_HANDSHAKE_EN adds sample_ready, makes
// sample_valid level-held until accepted and activates the sticky overrun flag.
//
// state | meaning
// SYNC  | discarding data, waiting for a right-to-left LRCK edge
// LEFT  | collecting the left word
// RIGHT | collecting the right word; pair is published at its end
module i2s_adc_rx #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          aud_bclk,
  input  logic          aud_adclrck,
  input  logic          aud_adcdat,
  input  logic          enable,
  output logic [DW-1:0] left,
  output logic [DW-1:0] right,
  output logic          sample_valid,
`ifdef I2S_RX_HANDSHAKE_EN
  input  logic          sample_ready,
`endif
  output logic          overrun
);

  localparam logic [4:0] DW5 = 5'(DW);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t        state;
  logic [1:0]    bclk_sync;
  logic [1:0]    lrck_sync;
  logic [1:0]    dat_sync;
  logic          bclk_d;
  logic          lrck_d;
  logic [4:0]    bitcnt;
  logic [DW-1:0] shreg;
  logic [DW-1:0] lhold;

  logic          bclk_rise;
  logic          lrck;
  logic          dat;
  logic          lr_edge;
  logic          shift_en;
  logic [DW-1:0] shreg_nxt;
  logic [4:0]    bitcnt_inc;
  logic [4:0]    taken;
  logic [DW-1:0] word_fin;

  // Two-flop synchronisers on all pins plus an edge flop on BCLK.
  // LRCK resets high so it agrees with the lrck_d reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= 2'b00;
      lrck_sync <= 2'b11;
      dat_sync  <= 2'b00;
      bclk_d    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], aud_bclk};
      lrck_sync <= {lrck_sync[0], aud_adclrck};
      dat_sync  <= {dat_sync[0], aud_adcdat};
      bclk_d    <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_d;
  assign lrck      = lrck_sync[1];
  assign dat       = dat_sync[1];
  assign lr_edge   = lrck ^ lrck_d;

  // Shift/count rules for one BCLK rise; the word is left-aligned at the end.
  // Stale bits from the previous word sit above the new ones and fall off the
  // top during the alignment shift.
  always_comb begin
    shift_en   = (bitcnt < DW5);
    shreg_nxt  = shift_en ? {shreg[DW-2:0], dat} : shreg;
    bitcnt_inc = (bitcnt == 5'd31) ? 5'd31 : bitcnt + 5'd1;
    taken      = shift_en ? bitcnt + 5'd1 : DW5;
    word_fin   = shreg_nxt << (DW5 - taken);
  end

  // Bit shifter, bit counter and previous-LRCK register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bitcnt <= 5'd0;
      lrck_d <= 1'b1;
    end else begin
      if (bclk_rise) begin
        shreg  <= shreg_nxt;
        lrck_d <= lrck;
      end
      if (!enable) begin
        bitcnt <= 5'd0;
      end else if (bclk_rise) begin
        bitcnt <= lr_edge ? 5'd0 : bitcnt_inc;
      end
    end
  end

  // Frame FSM with registered sample outputs and valid/overrun flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SYNC;
      lhold        <= '0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
`ifdef I2S_RX_HANDSHAKE_EN
      overrun      <= 1'b0;
`endif
    end else begin
`ifdef I2S_RX_HANDSHAKE_EN
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
`else
      sample_valid <= 1'b0;
`endif
      if (!enable) begin
        state <= SYNC;
      end else if (bclk_rise && lr_edge) begin
        case (state)
          SYNC: begin
            if (!lrck) begin
              state <= LEFT;
            end
          end
          LEFT: begin
            lhold <= word_fin;
            state <= RIGHT;
          end
          RIGHT: begin
            left         <= lhold;
            right        <= word_fin;
            sample_valid <= 1'b1;
`ifdef I2S_RX_HANDSHAKE_EN
            if (sample_valid && !sample_ready) begin
              overrun <= 1'b1;
            end
`endif
            state <= LEFT;
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

`ifndef I2S_RX_HANDSHAKE_EN
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Self-checking bench for i2s_adc_rx: drives an I2S transmitter model and
// compares captured pairs against words computed from the slot contents.
module tb_i2s_adc_rx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aud_bclk = 1'b0;
  logic          aud_adclrck = 1'b1;
  logic          aud_adcdat = 1'b0;
  logic          enable = 1'b1;
  logic [DW-1:0] left;
  logic [DW-1:0] right;
  logic          sample_valid;
  logic          overrun;
`ifdef I2S_RX_HANDSHAKE_EN
  logic          sample_ready = 1'b1;
`endif

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    pulses = 0;
  int    pushed = 0;
  logic  prev_bit = 1'b0;
  logic  prev_valid = 1'b0;
  logic  mon_en = 1'b1;
  logic  take;

  always #18 clk = ~clk;

  i2s_adc_rx #(.DW(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .aud_bclk(aud_bclk),
    .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat),
    .enable(enable),
    .left(left),
    .right(right),
    .sample_valid(sample_valid),
`ifdef I2S_RX_HANDSHAKE_EN
    .sample_ready(sample_ready),
`endif
    .overrun(overrun)
  );

`ifdef I2S_RX_HANDSHAKE_EN
  assign take = sample_valid & sample_ready;
`else
  assign take = sample_valid;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected capture: first DW bits of the n-bit slot, left-aligned.
  function automatic logic [DW-1:0] model_word(input int n, input logic [31:0] v);
    logic [31:0] m;
    m = (n >= 32) ? v : (v & ((32'd1 << n) - 32'd1));
    if (n >= DW) return DW'(m >> (n - DW));
    else         return DW'(m << (DW - n));
  endfunction

  // One BCLK period: LRCK and data change with the falling edge; data lags
  // the word by one period (I2S delay). 4 clk low, 4 clk high.
  task automatic period(input logic l, input logic b);
    aud_adclrck = l;
    aud_adcdat  = prev_bit;
    prev_bit    = b;
    repeat (4) @(negedge clk);
    aud_bclk = 1'b1;
    repeat (4) @(negedge clk);
    aud_bclk = 1'b0;
  endtask

  task automatic send_word(input logic l, input int n, input logic [31:0] v,
                           input int from, input int to);
    for (int i = from; i < to; i++) period(l, v[n-1-i]);
  endtask

  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    exp_q.push_back(p);
    pushed++;
  endtask

  task automatic frame(input int nl, input logic [31:0] vl, input int nr,
                       input logic [31:0] vr, input bit expect_out);
    send_word(1'b0, nl, vl, 0, nl);
    send_word(1'b1, nr, vr, 0, nr);
    if (expect_out) push_pair(model_word(nl, vl), model_word(nr, vr));
  endtask

  // Flush the pending pair with a 1-bit left word, check bookkeeping, then
  // close a 1+1-bit zero frame that the next section will flush.
  task automatic drain(input string tag);
    send_word(1'b0, 1, 32'd0, 0, 1);
    repeat (4) @(negedge clk);
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_errors++;
      $error("FAIL %s_pending: observed %0d expected 0", tag, exp_q.size());
    end
    check({tag, "_pulses"}, pulses, pushed);
    send_word(1'b1, 1, 32'd0, 0, 1);
    push_pair('0, '0);
  endtask

  // Pair monitor: every accepted pair must match the head of the model queue.
  always @(negedge clk) begin
    pair_t p;
    if (rst_n && mon_en && take) begin
      pulses++;
      check("strobe_width", 32'(prev_valid), 32'd0);
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL unexpected_pair: observed left %h right %h expected none", left, right);
      end
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("left", 32'(left), 32'(p.l));
        check("right", 32'(right), 32'(p.r));
      end
    end
    prev_valid = sample_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, c, d;
    int nl, nr;

    repeat (3) @(negedge clk);
    check("rst_left", 32'(left), 32'd0);
    check("rst_right", 32'(right), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Reset released in the middle of a right word
    a = $urandom;
    send_word(1'b1, 32, a, 0, 10);
    rst_n = 1'b1;
    send_word(1'b1, 32, a, 10, 32);
    check("midframe_no_valid", pulses, 0);

    // Basic capture, 32-bit slots
    frame(32, {16'h1234, 16'($urandom)}, 32, {16'hFEDC, 16'($urandom)}, 1'b1);
    for (int k = 0; k < 3; k++) frame(32, $urandom, 32, $urandom, 1'b1);
    drain("basic");

    // Short and long words
    frame(12, 32'h0000_0ABC, 12, $urandom, 1'b1);
    frame(16, $urandom, 24, $urandom, 1'b1);
    for (int k = 0; k < 4; k++) begin
      nl = $urandom_range(1, 32);
      nr = $urandom_range(1, 32);
      frame(nl, $urandom, nr, $urandom, 1'b1);
    end
    drain("short");

    // Enable dropped during a left word
    frame(32, $urandom, 32, $urandom, 1'b1);
    c = $urandom;
    d = $urandom;
    send_word(1'b0, 32, c, 0, 10);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    send_word(1'b0, 32, c, 10, 32);
    send_word(1'b1, 32, d, 0, 32);
    frame(32, $urandom, 32, $urandom, 1'b1);
    frame(24, $urandom, 32, $urandom, 1'b1);
    drain("disable");

    // Asynchronous reset during a right word
    frame(32, $urandom, 32, $urandom, 1'b1);
    c = $urandom;
    d = $urandom;
    send_word(1'b0, 32, c, 0, 32);
    send_word(1'b1, 32, d, 0, 12);
    #5 rst_n = 1'b0;
    #1;
    check("arst_left", 32'(left), 32'd0);
    check("arst_right", 32'(right), 32'd0);
    check("arst_valid", 32'(sample_valid), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    @(negedge clk);
    send_word(1'b1, 32, d, 12, 20);
    rst_n = 1'b1;
    send_word(1'b1, 32, d, 20, 32);
    frame(32, $urandom, 32, $urandom, 1'b1);
    frame(32, $urandom, 16, $urandom, 1'b1);
    drain("reset");

`ifdef I2S_RX_HANDSHAKE_EN
    // Backpressure across two frames
    a = $urandom;
    b = $urandom;
    c = $urandom;
    d = $urandom;
    send_word(1'b0, 32, a, 0, 1);
    mon_en = 1'b0;
    sample_ready = 1'b0;
    send_word(1'b0, 32, a, 1, 32);
    send_word(1'b1, 32, b, 0, 32);
    frame(32, c, 32, d, 1'b0);
    send_word(1'b0, 1, 32'd0, 0, 1);
    repeat (4) @(negedge clk);
    check("bp_valid", 32'(sample_valid), 32'd1);
    check("bp_left", 32'(left), 32'(model_word(32, c)));
    check("bp_right", 32'(right), 32'(model_word(32, d)));
    check("bp_overrun", 32'(overrun), 32'd1);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    check("bp_accept_valid", 32'(sample_valid), 32'd0);
    check("bp_accept_overrun", 32'(overrun), 32'd1);
    sample_ready = 1'b1;
    mon_en = 1'b1;
    send_word(1'b1, 1, 32'd0, 0, 1);
    push_pair('0, '0);
    frame(32, $urandom, 32, $urandom, 1'b1);
`endif

    drain("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
